alu_issue_ctrl: RTL and testbench

//  Initiator side of the 16-bit ALU interface: accepts packed instructions over valid/ready,

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode, instruction field positions and issue-controller state encoding.
// Used by the issue controller, the ALU itself and their benches.
package alu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int IMM_W_DEF  = 6;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    NOT = 3'd2,
    SHL = 3'd3,
    SHR = 3'd4,
    AND = 3'd5,
    OR  = 3'd6,
    SLT = 3'd7
  } alu_op_e;

  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 13;
  localparam int RD_MSB      = 12;
  localparam int RD_LSB      = 10;
  localparam int RS1_MSB     = 9;
  localparam int RS1_LSB     = 7;
  localparam int IMM_SEL_BIT = 6;
  localparam int RS2_MSB     = 5;
  localparam int RS2_LSB     = 3;
  localparam int IMM_MSB     = 5;
  localparam int IMM_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: two async read ports, two sync write ports (A beats B), r0 reads zero.
// Writes land on the rising edge; reads return pre-edge contents (no bypass).
module alu_regfile #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [2:0]        rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_a_en,
  input  logic [2:0]        wr_a_addr,
  input  logic [DATA_W-1:0] wr_a_data,
  input  logic              wr_b_en,
  input  logic [2:0]        wr_b_addr,
  input  logic [DATA_W-1:0] wr_b_data
);

  logic [7:0][DATA_W-1:0] mem_q;
  logic [7:0][DATA_W-1:0] mem_d;

  // Port B is applied first so a same-address port A write overrides it.
  always_comb begin
    mem_d = mem_q;
    if (wr_b_en) mem_d[wr_b_addr] = wr_b_data;
    if (wr_a_en) mem_d[wr_a_addr] = wr_a_data;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rd_a_data = mem_q[rd_a_addr];
  assign rd_b_data = mem_q[rd_b_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accept instr, drive registered operands one cycle, write back, present result.
// Accept at T, ALU driven T+1, res_valid at T+2; one instruction in flight, held until res_ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              rf_wr_en,
  input  logic [2:0]        rf_wr_addr,
  input  logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        ALU_Control,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic              zero_flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic [2:0]        res_rd
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  alu_op_e           alu_ctrl_q, alu_ctrl_d;
  logic [2:0]        rd_q, rd_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d;
  logic [2:0]        res_rd_q, res_rd_d;

  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] imm_ext;
  logic              accept;
  logic              wb_en;

  assign accept  = (state_q == IDLE) && instr_valid;
  assign wb_en   = (state_q == ISSUE);
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_LSB +: IMM_W]};

  alu_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_a_addr (instr[RS1_MSB:RS1_LSB]),
    .rd_a_data (rs1_data),
    .rd_b_addr (instr[RS2_MSB:RS2_LSB]),
    .rd_b_data (rs2_data),
    .wr_a_en   (wb_en),
    .wr_a_addr (rd_q),
    .wr_a_data (ALU_out),
    .wr_b_en   (rf_wr_en),
    .wr_b_addr (rf_wr_addr),
    .wr_b_data (rf_wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == IDLE);
    res_valid   = (state_q == RESP);
  end

  // Operand registers only move on acceptance so the ALU inputs hold between instructions.
  always_comb begin
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    alu_ctrl_d = alu_ctrl_q;
    rd_d       = rd_q;
    res_data_d = res_data_q;
    res_zero_d = res_zero_q;
    res_rd_d   = res_rd_q;
    if (accept) begin
      alu_in1_d  = rs1_data;
      alu_in2_d  = instr[IMM_SEL_BIT] ? imm_ext : rs2_data;
      alu_ctrl_d = alu_op_e'(instr[OP_MSB:OP_LSB]);
      rd_d       = instr[RD_MSB:RD_LSB];
    end
    if (wb_en) begin
      res_data_d = ALU_out;
      res_zero_d = zero_flag;
      res_rd_d   = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      alu_ctrl_q <= ADD;
      rd_q       <= '0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_rd_q   <= '0;
    end else begin
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      alu_ctrl_q <= alu_ctrl_d;
      rd_q       <= rd_d;
      res_data_q <= res_data_d;
      res_zero_q <= res_zero_d;
      res_rd_q   <= res_rd_d;
    end
  end

  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign ALU_Control = alu_ctrl_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_rd      = res_rd_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU on the far side.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [2:0]  ALU_Control;
  logic [15:0] ALU_out;
  logic        zero_flag;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_zero;
  logic [2:0]  res_rd;

  int n_total = 0;
  int n_pass  = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .ALU_Control (ALU_Control),
    .ALU_out     (ALU_out),
    .zero_flag   (zero_flag),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_rd      (res_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] alu_res;
  always_comb begin
    alu_res = 16'd0;
    case (alu_op_e'(ALU_Control))
      ADD: alu_res = alu_in1 + alu_in2;
      SUB: alu_res = alu_in1 - alu_in2;
      NOT: alu_res = ~alu_in1;
      SHL: alu_res = alu_in1 << alu_in2;
      SHR: alu_res = alu_in1 >> alu_in2;
      AND: alu_res = alu_in1 & alu_in2;
      OR:  alu_res = alu_in1 | alu_in2;
      SLT: alu_res = ($signed(alu_in1) < $signed(alu_in2)) ? 16'd1 : 16'd0;
      default: alu_res = 16'd0;
    endcase
  end
  assign ALU_out   = alu_res;
  assign zero_flag = (alu_res == 16'd0);

  function automatic logic [15:0] enc_r(input alu_op_e op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input alu_op_e op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [5:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string what,
                       input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
  endtask

  task automatic accept(input string tag, input logic [15:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    check(tag, "instr_ready_idle", 16'(instr_ready), 16'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic exec(input string tag, input logic [15:0] ins,
                      input logic [15:0] e1, input logic [15:0] e2, input logic [2:0] ectl,
                      input logic [15:0] edat, input logic ez, input logic [2:0] erd);
    res_ready = 1'b1;
    accept(tag, ins);
    check(tag, "alu_in1", alu_in1, e1);
    check(tag, "alu_in2", alu_in2, e2);
    check(tag, "ALU_Control", 16'(ALU_Control), 16'(ectl));
    check(tag, "instr_ready_issue", 16'(instr_ready), 16'd0);
    check(tag, "res_valid_issue", 16'(res_valid), 16'd0);
    tick();
    check(tag, "res_valid", 16'(res_valid), 16'd1);
    check(tag, "res_data", res_data, edat);
    check(tag, "res_zero", 16'(res_zero), 16'(ez));
    check(tag, "res_rd", 16'(res_rd), 16'(erd));
    tick();
    check(tag, "res_valid_after", 16'(res_valid), 16'd0);
  endtask

  // OR r0, rN, r0 returns rN without writing anything back.
  task automatic readback(input string tag, input logic [2:0] n, input logic [15:0] v);
    exec(tag, enc_r(OR, 3'd0, n, 3'd0), v, 16'd0, OR, v, (v == 16'd0), 3'd0);
  endtask

  task automatic ext_load(input logic [2:0] a, input logic [15:0] d);
    rf_wr_en   = 1'b1;
    rf_wr_addr = a;
    rf_wr_data = d;
    tick();
    rf_wr_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'd0;
    rf_wr_en    = 1'b0;
    rf_wr_addr  = 3'd0;
    rf_wr_data  = 16'd0;
    res_ready   = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("reset", "instr_ready", 16'(instr_ready), 16'd1);
    check("reset", "res_valid", 16'(res_valid), 16'd0);
    check("reset", "alu_in1", alu_in1, 16'd0);
    check("reset", "alu_in2", alu_in2, 16'd0);
    check("reset", "ALU_Control", 16'(ALU_Control), 16'd0);
    check("reset", "res_data", res_data, 16'd0);
    check("reset", "res_zero", 16'(res_zero), 16'd0);
    check("reset", "res_rd", 16'(res_rd), 16'd0);

    ext_load(3'd1, 16'd5);
    ext_load(3'd2, 16'd3);
    exec("add_r3", enc_r(ADD, 3'd3, 3'd1, 3'd2), 16'd5, 16'd3, 3'd0, 16'd8, 1'b0, 3'd3);
    exec("add_r4", enc_r(ADD, 3'd4, 3'd3, 3'd0), 16'd8, 16'd0, 3'd0, 16'd8, 1'b0, 3'd4);
    check("hold", "alu_in1", alu_in1, 16'd8);
    check("hold", "res_data", res_data, 16'd8);

    exec("sub_r4", enc_r(SUB, 3'd4, 3'd1, 3'd1), 16'd5, 16'd5, 3'd1, 16'd0, 1'b1, 3'd4);
    exec("shl_r5", enc_i(SHL, 3'd5, 3'd1, 6'd2), 16'd5, 16'd2, 3'd3, 16'd20, 1'b0, 3'd5);
    exec("slt_imm", enc_i(SLT, 3'd6, 3'd2, 6'd7), 16'd3, 16'd7, 3'd7, 16'd1, 1'b0, 3'd6);
    exec("slt_reg", enc_r(SLT, 3'd6, 3'd1, 3'd2), 16'd5, 16'd3, 3'd7, 16'd0, 1'b1, 3'd6);
    readback("rb_r4", 3'd4, 16'd0);
    readback("rb_r5", 3'd5, 16'd20);

    // Result held under backpressure while a new instruction waits.
    res_ready = 1'b0;
    accept("bp", enc_r(AND, 3'd7, 3'd1, 3'd2));
    check("bp", "alu_in1", alu_in1, 16'd5);
    check("bp", "ALU_Control", 16'(ALU_Control), 16'd5);
    tick();
    instr       = enc_r(OR, 3'd0, 3'd7, 3'd0);
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_stall", "res_valid", 16'(res_valid), 16'd1);
      check("bp_stall", "res_data", res_data, 16'd1);
      check("bp_stall", "res_rd", 16'(res_rd), 16'd7);
      check("bp_stall", "instr_ready", 16'(instr_ready), 16'd0);
      check("bp_stall", "alu_in1", alu_in1, 16'd5);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_release", "res_valid", 16'(res_valid), 16'd0);
    check("bp_release", "instr_ready", 16'(instr_ready), 16'd1);
    check("bp_release", "alu_in1_not_yet", alu_in1, 16'd5);
    tick();
    instr_valid = 1'b0;
    check("bp_pending", "alu_in1", alu_in1, 16'd1);
    check("bp_pending", "ALU_Control", 16'(ALU_Control), 16'd6);
    check("bp_pending", "instr_ready", 16'(instr_ready), 16'd0);
    tick();
    check("bp_pending", "res_data", res_data, 16'd1);
    check("bp_pending", "res_rd", 16'(res_rd), 16'd0);
    tick();

    // r0 is never written.
    exec("or_r0", enc_r(OR, 3'd0, 3'd1, 3'd2), 16'd5, 16'd3, 3'd6, 16'd7, 1'b0, 3'd0);
    readback("rb_r0", 3'd0, 16'd0);
    ext_load(3'd0, 16'd9);
    exec("add_r7_r0", enc_r(ADD, 3'd7, 3'd0, 3'd0), 16'd0, 16'd0, 3'd0, 16'd0, 1'b1, 3'd7);
    readback("rb_r7", 3'd7, 16'd0);

    // External load on the accept edge: operands see the old r1.
    res_ready  = 1'b1;
    rf_wr_en   = 1'b1;
    rf_wr_addr = 3'd1;
    rf_wr_data = 16'd100;
    accept("ld_acc", enc_r(ADD, 3'd3, 3'd1, 3'd0));
    rf_wr_en = 1'b0;
    check("ld_acc", "alu_in1", alu_in1, 16'd5);
    tick();
    check("ld_acc", "res_data", res_data, 16'd5);
    tick();
    readback("rb_r1_loaded", 3'd1, 16'd100);

    // External load colliding with writeback: writeback wins.
    accept("wb_conflict", enc_r(ADD, 3'd3, 3'd1, 3'd2));
    rf_wr_en   = 1'b1;
    rf_wr_addr = 3'd3;
    rf_wr_data = 16'h0055;
    check("wb_conflict", "alu_in1", alu_in1, 16'd100);
    tick();
    rf_wr_en = 1'b0;
    check("wb_conflict", "res_data", res_data, 16'd103);
    tick();
    readback("rb_r3_conflict", 3'd3, 16'd103);

    // Reset during ISSUE drops the instruction and clears the register file.
    accept("rst_mid", enc_r(ADD, 3'd3, 3'd1, 3'd2));
    check("rst_mid", "alu_in1", alu_in1, 16'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid", "instr_ready", 16'(instr_ready), 16'd1);
    check("rst_mid", "res_valid", 16'(res_valid), 16'd0);
    check("rst_mid", "res_data", res_data, 16'd0);
    check("rst_mid", "alu_in1", alu_in1, 16'd0);
    tick();
    check("rst_mid", "res_valid_stays_low", 16'(res_valid), 16'd0);
    for (int r = 1; r < 8; r++) readback("rst_rb", 3'(r), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
